// File: rtl/auto_tiling_pkg.sv
// Shared constants for the im2col tile walker: matrix shape, lane count,
// derived tile counts, row stride and counter widths.
package auto_tiling_pkg;

    localparam int K_DIM  = 147;  // reduction rows (7*7*3)
    localparam int N_DIM  = 25;   // output positions (columns)
    localparam int LANES  = 16;   // systolic array height and tile edge
    localparam int ADDR_W = 15;   // read-address width

    localparam int KT_NUM     = (K_DIM + LANES - 1) / LANES;
    localparam int NT_NUM     = (N_DIM + LANES - 1) / LANES;
    localparam int ROW_STRIDE = LANES * N_DIM;  // base step per row tile
    localparam int CALC_W     = ADDR_W + 1;     // internal address precision

    // Counter width that never collapses to zero bits.
    function automatic int cnt_w(input int v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

    localparam int TW  = cnt_w(LANES);
    localparam int NTW = cnt_w(NT_NUM);
    localparam int KTW = cnt_w(KT_NUM);
    localparam int NW  = cnt_w(NT_NUM * LANES);  // column index n
    localparam int KW  = cnt_w(KT_NUM * LANES);  // row index k

endpackage

// File: rtl/auto_tiling_lane.sv
// One array lane: tracks its row k and row base k*N_DIM incrementally,
// adds the current column and registers the lane's address and valid.
// With AUTOTILING_ZERO_INVALID_ADDR_EN defined, invalid lanes drive address 0.
module auto_tiling_lane
    import auto_tiling_pkg::*;
#(
    parameter int LANE_IDX = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              emit,     // a position is emitted this edge
    input  logic              row_adv,  // step to the next row tile this edge
    input  logic [NW-1:0]     col,      // n of the emitted position
    input  logic              col_ok,   // n < N_DIM
    output logic [ADDR_W-1:0] addr,
    output logic              valid
);

    localparam logic [CALC_W-1:0] BASE0 = CALC_W'(LANE_IDX * N_DIM);
    localparam logic [KW-1:0]     K0    = KW'(LANE_IDX);

    logic [CALC_W-1:0] base;
    logic [KW-1:0]     krow;
    logic [CALC_W-1:0] sum;
    logic [ADDR_W-1:0] sum_trunc;
    logic              valid_nxt;
    logic [ADDR_W-1:0] addr_nxt;

    // Address and range check for the position being emitted.
    always_comb begin
        sum       = base + CALC_W'(col);
        sum_trunc = ADDR_W'(sum);
        valid_nxt = (int'(krow) < K_DIM) && col_ok;
`ifdef AUTOTILING_ZERO_INVALID_ADDR_EN
        addr_nxt  = valid_nxt ? sum_trunc : '0;
`else
        addr_nxt  = sum_trunc;
`endif
    end

    // Output register plus the per-lane row base that advances per row tile.
    always_ff @(posedge clk) begin
        if (rst) begin
            base  <= BASE0;
            krow  <= K0;
            addr  <= '0;
            valid <= 1'b0;
        end else begin
            if (emit) begin
                addr  <= addr_nxt;
                valid <= valid_nxt;
            end else begin
                valid <= 1'b0;
            end
            if (row_adv) begin
                base <= base + CALC_W'(ROW_STRIDE);
                krow <= krow + KW'(LANES);
            end
        end
    end

endmodule

// File: rtl/auto_tiling_input.sv
// im2col activation address generator: walks kt (outer), nt, t (inner)
// and emits one LANES-wide address vector per enabled cycle.
// Optional build macro: AUTOTILING_ZERO_INVALID_ADDR_EN (see lane module).
module auto_tiling_input
    import auto_tiling_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              io_enable,
    output logic [ADDR_W-1:0] io_rdAddr_0,
    output logic [ADDR_W-1:0] io_rdAddr_1,
    output logic [ADDR_W-1:0] io_rdAddr_2,
    output logic [ADDR_W-1:0] io_rdAddr_3,
    output logic [ADDR_W-1:0] io_rdAddr_4,
    output logic [ADDR_W-1:0] io_rdAddr_5,
    output logic [ADDR_W-1:0] io_rdAddr_6,
    output logic [ADDR_W-1:0] io_rdAddr_7,
    output logic [ADDR_W-1:0] io_rdAddr_8,
    output logic [ADDR_W-1:0] io_rdAddr_9,
    output logic [ADDR_W-1:0] io_rdAddr_10,
    output logic [ADDR_W-1:0] io_rdAddr_11,
    output logic [ADDR_W-1:0] io_rdAddr_12,
    output logic [ADDR_W-1:0] io_rdAddr_13,
    output logic [ADDR_W-1:0] io_rdAddr_14,
    output logic [ADDR_W-1:0] io_rdAddr_15,
    output logic              io_addrValid_0,
    output logic              io_addrValid_1,
    output logic              io_addrValid_2,
    output logic              io_addrValid_3,
    output logic              io_addrValid_4,
    output logic              io_addrValid_5,
    output logic              io_addrValid_6,
    output logic              io_addrValid_7,
    output logic              io_addrValid_8,
    output logic              io_addrValid_9,
    output logic              io_addrValid_10,
    output logic              io_addrValid_11,
    output logic              io_addrValid_12,
    output logic              io_addrValid_13,
    output logic              io_addrValid_14,
    output logic              io_addrValid_15,
    output logic              io_done
);

    logic [TW-1:0]  t;
    logic [NTW-1:0] nt;
    logic [KTW-1:0] kt;
    logic [NW-1:0]  n_cur;   // nt*LANES + t, kept as its own counter
    logic           done;
    logic           emit, last, t_wrap, nt_wrap, row_adv, col_ok;

    logic [LANES-1:0][ADDR_W-1:0] lane_addr;
    logic [LANES-1:0]             lane_valid;

    // Walk control: emit while enabled and not finished; detect wraps.
    always_comb begin
        emit    = io_enable && !done;
        t_wrap  = (t == TW'(LANES - 1));
        nt_wrap = (nt == NTW'(NT_NUM - 1));
        last    = t_wrap && nt_wrap && (kt == KTW'(KT_NUM - 1));
        row_adv = emit && t_wrap && nt_wrap && !last;
        col_ok  = int'(n_cur) < N_DIM;
    end

    // Position counters and sticky done; counters freeze on the last position.
    always_ff @(posedge clock) begin
        if (reset) begin
            t     <= '0;
            nt    <= '0;
            kt    <= '0;
            n_cur <= '0;
            done  <= 1'b0;
        end else if (emit) begin
            if (last) begin
                done <= 1'b1;
            end else if (t_wrap) begin
                t <= '0;
                if (nt_wrap) begin
                    nt    <= '0;
                    n_cur <= '0;
                    kt    <= kt + 1'b1;
                end else begin
                    nt    <= nt + 1'b1;
                    n_cur <= n_cur + 1'b1;
                end
            end else begin
                t     <= t + 1'b1;
                n_cur <= n_cur + 1'b1;
            end
        end
    end

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        auto_tiling_lane #(.LANE_IDX(j)) u_lane (
            .clk     (clock),
            .rst     (reset),
            .emit    (emit),
            .row_adv (row_adv),
            .col     (n_cur),
            .col_ok  (col_ok),
            .addr    (lane_addr[j]),
            .valid   (lane_valid[j])
        );
    end

    assign io_done = done;

    assign io_rdAddr_0  = lane_addr[0];
    assign io_rdAddr_1  = lane_addr[1];
    assign io_rdAddr_2  = lane_addr[2];
    assign io_rdAddr_3  = lane_addr[3];
    assign io_rdAddr_4  = lane_addr[4];
    assign io_rdAddr_5  = lane_addr[5];
    assign io_rdAddr_6  = lane_addr[6];
    assign io_rdAddr_7  = lane_addr[7];
    assign io_rdAddr_8  = lane_addr[8];
    assign io_rdAddr_9  = lane_addr[9];
    assign io_rdAddr_10 = lane_addr[10];
    assign io_rdAddr_11 = lane_addr[11];
    assign io_rdAddr_12 = lane_addr[12];
    assign io_rdAddr_13 = lane_addr[13];
    assign io_rdAddr_14 = lane_addr[14];
    assign io_rdAddr_15 = lane_addr[15];

    assign io_addrValid_0  = lane_valid[0];
    assign io_addrValid_1  = lane_valid[1];
    assign io_addrValid_2  = lane_valid[2];
    assign io_addrValid_3  = lane_valid[3];
    assign io_addrValid_4  = lane_valid[4];
    assign io_addrValid_5  = lane_valid[5];
    assign io_addrValid_6  = lane_valid[6];
    assign io_addrValid_7  = lane_valid[7];
    assign io_addrValid_8  = lane_valid[8];
    assign io_addrValid_9  = lane_valid[9];
    assign io_addrValid_10 = lane_valid[10];
    assign io_addrValid_11 = lane_valid[11];
    assign io_addrValid_12 = lane_valid[12];
    assign io_addrValid_13 = lane_valid[13];
    assign io_addrValid_14 = lane_valid[14];
    assign io_addrValid_15 = lane_valid[15];

endmodule

// File: tb/tb_auto_tiling_input.sv
// Randomized-enable bench for auto_tiling_input against a position-index
// reference model (p -> kt, nt, t -> addr/valid per lane).
module tb_auto_tiling_input;
    import auto_tiling_pkg::*;

    localparam int TOTAL = KT_NUM * NT_NUM * LANES;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic io_enable = 1'b0;
    logic io_done;
    logic [15:0][ADDR_W-1:0] rd;
    logic [15:0]             av;

    int n_checks = 0;
    int n_fail   = 0;

    // reference state
    int m_pos = 0;
    bit m_done = 1'b0;
    int m_addr [16];
    bit m_valid [16];

    always #5 clock = ~clock;

    auto_tiling_input dut (
        .clock(clock), .reset(reset), .io_enable(io_enable),
        .io_rdAddr_0(rd[0]),   .io_rdAddr_1(rd[1]),   .io_rdAddr_2(rd[2]),   .io_rdAddr_3(rd[3]),
        .io_rdAddr_4(rd[4]),   .io_rdAddr_5(rd[5]),   .io_rdAddr_6(rd[6]),   .io_rdAddr_7(rd[7]),
        .io_rdAddr_8(rd[8]),   .io_rdAddr_9(rd[9]),   .io_rdAddr_10(rd[10]), .io_rdAddr_11(rd[11]),
        .io_rdAddr_12(rd[12]), .io_rdAddr_13(rd[13]), .io_rdAddr_14(rd[14]), .io_rdAddr_15(rd[15]),
        .io_addrValid_0(av[0]),   .io_addrValid_1(av[1]),   .io_addrValid_2(av[2]),   .io_addrValid_3(av[3]),
        .io_addrValid_4(av[4]),   .io_addrValid_5(av[5]),   .io_addrValid_6(av[6]),   .io_addrValid_7(av[7]),
        .io_addrValid_8(av[8]),   .io_addrValid_9(av[9]),   .io_addrValid_10(av[10]), .io_addrValid_11(av[11]),
        .io_addrValid_12(av[12]), .io_addrValid_13(av[13]), .io_addrValid_14(av[14]), .io_addrValid_15(av[15]),
        .io_done(io_done)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (pos %0d)", tag, obs, exp, m_pos);
        end
    endtask

    // Model one clock edge from the specification's loop-order rules.
    task automatic model_edge(input bit r, input bit en);
        if (r) begin
            m_pos = 0;
            m_done = 1'b0;
            for (int j = 0; j < 16; j++) begin m_addr[j] = 0; m_valid[j] = 1'b0; end
        end else if (en && !m_done) begin
            int kt, nt, t, n, k, a;
            kt = m_pos / (NT_NUM * LANES);
            nt = (m_pos / LANES) % NT_NUM;
            t  = m_pos % LANES;
            n  = nt * LANES + t;
            for (int j = 0; j < 16; j++) begin
                k = kt * LANES + j;
                a = (k * N_DIM + n) % (1 << ADDR_W);
                m_valid[j] = (k < K_DIM) && (n < N_DIM);
`ifdef AUTOTILING_ZERO_INVALID_ADDR_EN
                if (!m_valid[j]) a = 0;
`endif
                m_addr[j] = a;
            end
            m_pos++;
            if (m_pos == TOTAL) m_done = 1'b1;
        end else begin
            for (int j = 0; j < 16; j++) m_valid[j] = 1'b0;
        end
    endtask

    task automatic check_all();
        for (int j = 0; j < 16; j++) begin
            chk($sformatf("addr%0d", j), int'(rd[j]), m_addr[j]);
            chk($sformatf("valid%0d", j), int'(av[j]), int'(m_valid[j]));
        end
        chk("done", int'(io_done), int'(m_done));
    endtask

    task automatic step(input bit r, input bit en);
        reset = r;
        io_enable = en;
        @(posedge clock);
        #1;
        model_edge(r, en);
        check_all();
    endtask

    // Hand-derived spot values taken straight from the matrix layout.
    task automatic spot_checks();
        if (m_pos == 1 && av[0]) begin
            chk("first_lane1", int'(rd[1]), 25);
            chk("first_lane15", int'(rd[15]), 375);
        end
        if (m_pos == 16 && av[0]) begin
            chk("t15_lane0", int'(rd[0]), 15);
            chk("t15_lane15", int'(rd[15]), 390);
        end
        if (m_pos == 25 && av[0]) chk("n24_lane0", int'(rd[0]), 24);
        if (m_pos == 26 && io_enable) chk("n25_valid0", int'(av[0]), 0);
        if (m_pos == 9 * 32 + 16 + 9 && io_enable) begin
            chk("last_lane2_addr", int'(rd[2]), 3674);
            chk("last_lane2_valid", int'(av[2]), 1);
            chk("last_lane3_valid", int'(av[3]), 0);
`ifdef AUTOTILING_ZERO_INVALID_ADDR_EN
            chk("last_lane3_addr", int'(rd[3]), 0);
`endif
        end
    endtask

    initial begin
        int cyc;
        for (int j = 0; j < 16; j++) begin m_addr[j] = 0; m_valid[j] = 1'b0; end
        // reset for two cycles
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        // partial walk then mid-walk reset
        for (int i = 0; i < 40; i++) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        // dense walk with a fixed 5-cycle gap and random enables
        for (int i = 0; i < 20; i++) begin step(1'b0, 1'b1); spot_checks(); end
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0);
        cyc = 0;
        while (!m_done && cyc < 3000) begin
            step(1'b0, ($urandom_range(0, 3) != 0));
            spot_checks();
            cyc++;
        end
        chk("walk_finished", int'(m_done), 1);
        chk("pos_count", m_pos, TOTAL);
        // enables after completion keep all valids low
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
